// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory.
// Holds the clear FSM states and the data-port address offset helper.
package mem_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } clr_state_e;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DATA_BASE = 128;
  localparam int unsigned DEF_CLR_VAL   = 0;

  // Offset an address by base, wrapping at 2**aw.
  function automatic int unsigned eff_addr(
    input int unsigned addr,
    input int unsigned base,
    input int unsigned aw
  );
    return (addr + base) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: walks every word once, then parks in READY.
// Busy stays high for exactly DEPTH cycles after reset release.
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  clr_state_e        r_state;
  clr_state_e        w_next;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    o_clr_we  = 1'b0;
    unique case (r_state)
      CLEAR: begin
        o_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt[ADDR_W-1:0] == {ADDR_W{1'b1}})
          w_next = READY;
      end
      READY: begin
        w_next = READY;
      end
      default: w_next = CLEAR;
    endcase
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_addr = r_cnt[ADDR_W-1:0];

endmodule

// File: rtl/unified_mem_ctrl.sv
// Shared instruction/data memory with clear sequencer and write-first bypass.
// Define MEM_WRITE_PROT_EN to block data writes into the instruction region.
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_BASE = DEF_DATA_BASE,
  parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(DEF_CLR_VAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_valid,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_data,
  output logic              d_valid,
  output logic              busy,
  output logic              prot_fault
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [ADDR_W-1:0] w_eff;
  logic              w_i_acc;
  logic              w_d_re;
  logic              w_d_we;
  logic              w_prot;
  logic              w_wr;
  logic [DATA_W-1:0] r_i_data;
  logic [DATA_W-1:0] r_d_data;
  logic              r_i_valid;
  logic              r_d_valid;

  mem_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk       (clk),
    .rst_n     (rst_n),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_addr(w_clr_addr)
  );

  assign w_eff   = ADDR_W'(eff_addr(32'(d_addr), DATA_BASE, ADDR_W));
  assign w_i_acc = i_en & ~w_busy;
  assign w_d_re  = d_re & ~w_busy;
  assign w_d_we  = d_we & ~w_busy;

`ifdef MEM_WRITE_PROT_EN
  logic r_prot;

  assign w_prot = w_d_we & (32'(w_eff) < DATA_BASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prot <= 1'b0;
    else        r_prot <= w_prot;
  end

  assign prot_fault = r_prot;
`else
  assign w_prot     = 1'b0;
  assign prot_fault = 1'b0;
`endif

  assign w_wr = w_d_we & ~w_prot;

  // Clear owns the array while busy, so the two writers never collide.
  always_ff @(posedge clk) begin
    if (w_clr_we)  r_mem[w_clr_addr] <= CLR_VAL;
    else if (w_wr) r_mem[w_eff]      <= d_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_data  <= '0;
      r_d_data  <= '0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
    end else begin
      r_i_valid <= w_i_acc;
      r_d_valid <= w_d_re;
      if (w_i_acc)
        r_i_data <= (w_wr && i_addr == w_eff) ? d_wdata : r_mem[i_addr];
      if (w_d_re)
        r_d_data <= w_wr ? d_wdata : r_mem[w_eff];
    end
  end

  assign i_data  = r_i_data;
  assign d_data  = r_d_data;
  assign i_valid = r_i_valid;
  assign d_valid = r_d_valid;
  assign busy    = w_busy;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Scoreboard bench for unified_mem_ctrl: directed requests push expected
// read words, a negedge monitor pops them whenever a valid pulse appears.
module tb_unified_mem_ctrl;

`ifdef MEM_WRITE_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_en = 1'b0;
  logic [7:0] i_addr = '0;
  logic [7:0] i_data;
  logic       i_valid;
  logic       d_re = 1'b0;
  logic       d_we = 1'b0;
  logic [7:0] d_addr = '0;
  logic [7:0] d_wdata = '0;
  logic [7:0] d_data;
  logic       d_valid;
  logic       busy;
  logic       prot_fault;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] q_i[$];
  logic [7:0] q_d[$];

  unified_mem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (i_en),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .d_re      (d_re),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_data    (d_data),
    .d_valid   (d_valid),
    .busy      (busy),
    .prot_fault(prot_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && i_valid) begin
      if (q_i.size() == 0) check("i_valid_unexpected", 1, 0);
      else check("i_data", int'(i_data), int'(q_i.pop_front()));
    end
    if (rst_n && d_valid) begin
      if (q_d.size() == 0) check("d_valid_unexpected", 1, 0);
      else check("d_data", int'(d_data), int'(q_d.pop_front()));
    end
  end

  task automatic req(
    input bit ie, input logic [7:0] ia,
    input bit re, input bit we,
    input logic [7:0] da, input logic [7:0] wd,
    input logic [7:0] ei, input logic [7:0] ed,
    input bit acc
  );
    @(negedge clk);
    i_en = ie; i_addr = ia;
    d_re = re; d_we = we; d_addr = da; d_wdata = wd;
    if (acc && ie) q_i.push_back(ei);
    if (acc && re) q_d.push_back(ed);
  endtask

  task automatic idle();
    @(negedge clk);
    i_en = 0; d_re = 0; d_we = 0;
  endtask

  task automatic count_busy(input string name);
    int cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check(name, cnt, 256);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 1);
    check("rst_i_valid", int'(i_valid), 0);
    check("rst_d_valid", int'(d_valid), 0);
    check("rst_prot", int'(prot_fault), 0);
    rst_n = 1'b1;
    count_busy("clear_len");

    req(1, 8'd0, 1, 0, 8'd3, 8'h00, 8'h00, 8'h00, 1);
    req(1, 8'd255, 1, 0, 8'd127, 8'h00, 8'h00, 8'h00, 1);

    req(0, 8'd0, 0, 1, 8'd5, 8'hA5, 8'h00, 8'h00, 1);
    req(1, 8'd133, 1, 0, 8'd5, 8'h00, 8'hA5, 8'hA5, 1);
    idle();
    idle();
    check("d_hold", int'(d_data), 8'hA5);

    req(1, 8'd138, 1, 1, 8'd10, 8'h3C, 8'h3C, 8'h3C, 1);
    req(1, 8'd138, 1, 0, 8'd10, 8'h00, 8'h3C, 8'h3C, 1);

    req(0, 8'd0, 0, 1, 8'd200, 8'h77, 8'h00, 8'h00, 1);
    idle();
    check("prot_pulse", int'(prot_fault), int'(PROT));
    idle();
    check("prot_drop", int'(prot_fault), 0);
    req(1, 8'd72, 1, 0, 8'd200, 8'h00,
        PROT ? 8'h00 : 8'h77, PROT ? 8'h00 : 8'h77, 1);
    idle();

    req(1, 8'd5, 1, 0, 8'd133, 8'h00, 8'h00, 8'h00, 1);
    idle();
    idle();
    check("d_nonzero_pre", int'(d_data), 0);

    req(1, 8'd133, 1, 0, 8'd5, 8'h00, 8'hA5, 8'hA5, 1);
    idle();
    idle();
    rst_n = 1'b0;
    #1;
    check("async_d_data", int'(d_data), 0);
    check("async_i_data", int'(i_data), 0);
    check("async_busy", int'(busy), 1);
    idle();
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      count_busy("clear_restart_len");
      begin
        req(1, 8'd133, 1, 1, 8'd5, 8'hFF, 8'h00, 8'h00, 0);
        idle();
      end
    join
    req(1, 8'd133, 1, 0, 8'd5, 8'h00, 8'h00, 8'h00, 1);
    idle();
    idle();
    check("busy_after", int'(busy), 0);
    check("q_i_empty", q_i.size(), 0);
    check("q_d_empty", q_d.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
- Parametrised successor to the team's von Neumann shared memory.
- Provides one instruction read port and one data read/write port, both registered.
- The data port applies a uniform DATA_BASE offset to both reads and writes.
- Adds a post-reset hardware clear sequencer, a busy handshake and write-first/bypass hazard rules; sits between the fetch and memory pipeline stages.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- DATA_BASE, 128, offset added to every data-port address, modulo DEPTH.
- CLR_VAL, 0, value written to every word during the clear sequence.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  instruction read request.
- i_addr  in  ADDR_W  instruction address, unmodified.
- i_data  out  DATA_W  registered instruction word.
- i_valid  out  1  i_data valid; pulses 1 cycle after an accepted i_en.
- d_re  in  1  data read request.
- d_we  in  1  data write request.
- d_addr  in  ADDR_W  data address; effective address = (d_addr + DATA_BASE) mod DEPTH.
- d_wdata  in  DATA_W  write data.
- d_data  out  DATA_W  registered data read word.
- d_valid  out  1  d_data valid; pulses 1 cycle after an accepted d_re.
- busy  out  1  clear sequence in progress; all requests are ignored while high.
- prot_fault  out  1  protection violation pulse (see Optional Feature).

Behaviour:
- Reset (async assert): i_data=0, d_data=0, i_valid=0, d_valid=0, prot_fault=0, busy=1, clear counter=0, FSM=CLEAR. Memory contents are not reset directly.
- FSM CLEAR:
  - Each cycle writes CLR_VAL to mem[cnt] and increments cnt.
  - When cnt==DEPTH-1 is written, go to READY; busy drops the following cycle.
  - The clear takes exactly DEPTH cycles after rst_n deasserts.
- FSM READY: busy=0. There is no exit except reset.
- Reset mid-clear restarts the clear from address 0.
- Request acceptance: a request is accepted when its enable is high and busy=0. Requests while busy=1 are dropped: no write, no valid pulse.
- Read latency: 1 cycle. d_data and i_data update only on an accepted read and otherwise hold their value. Valid flags are single-cycle pulses.
- Data write: mem[eff] updates at the clock edge when d_we is accepted.
- Simultaneous d_re and d_we: write-first. d_data returns d_wdata next cycle.
- Instruction hazard: accepted i_en with i_addr == eff while d_we is accepted in the same cycle bypasses, so i_data = d_wdata.
- Address arithmetic: the eff sum is ADDR_W wide and wraps. Example: d_addr=200 with DATA_BASE=128 gives eff=72.
- Both ports can read the same or different addresses in the same cycle without conflict.

Optional Feature:
- Macro: MEM_WRITE_PROT_EN
- Enabled:
  - A data write whose eff < DATA_BASE (the instruction region) is suppressed.
  - prot_fault pulses high for 1 cycle, registered in the cycle after the attempt.
  - A read issued in the same cycle still completes.
- Disabled:
  - All writes proceed.
  - prot_fault is tied to 0.

Decomposition:
- Package mem_pkg:
  - clear FSM state enum {CLEAR, READY};
  - default width/depth/base constants;
  - eff-address helper function.
- Sub-module mem_clear_seq: clear FSM plus ADDR_W+1-bit counter; outputs busy, clr_we, clr_addr.
- The top level contains the array, port muxing, bypass and protection logic.

Test Plan:
- Release rst_n, hold all requests: busy=1 for exactly 256 cycles, then 0. Any sampled read returns 0 afterwards.
- Issue d_we at d_addr=5, d_wdata=8'hA5, then d_re at d_addr=5: d_data=8'hA5 with d_valid one cycle after the read. i_en at i_addr=133 returns 8'hA5.
- Same-cycle d_re+d_we at d_addr=10, data 8'h3C: next-cycle d_data=8'h3C. In the same cycle, i_en at i_addr=138 gives i_data=8'h3C (bypass).
- Write d_addr=200, data 8'h77: memory word 72 = 8'h77 (wrap), readable via i_addr=72.
- Assert rst_n low midway (cycle 100) of the clear, then release: busy high for a full 256 cycles again. A d_we during busy leaves memory at 0 and produces no d_valid.
- With MEM_WRITE_PROT_EN defined, write d_addr=200 (eff 72): the word is unchanged and prot_fault pulses for 1 cycle. Without the macro, the word is written and prot_fault stays 0.
